// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller: address field
// positions, array geometry, fill FSM encodings and the latched-miss record.
package cache_pkg;

  localparam int TAG_MSB  = 15;
  localparam int TAG_LSB  = 10;
  localparam int SET_MSB  = 9;
  localparam int SET_LSB  = 4;
  localparam int WORD_MSB = 3;
  localparam int WORD_LSB = 1;

  localparam int NUM_SETS        = 64;
  localparam int WORDS_PER_BLOCK = 8;

  localparam int TAG_W  = TAG_MSB - TAG_LSB + 1;
  localparam int SET_W  = SET_MSB - SET_LSB + 1;
  localparam int WORD_W = WORD_MSB - WORD_LSB + 1;
  localparam int CNT_W  = WORD_W + 1;

  localparam logic [0:0] FILL_IDLE   = 1'b0;
  localparam logic [0:0] FILL_ACTIVE = 1'b1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  set;
    logic [WORD_W-1:0] word;
  } miss_info_t;

  // Word index visited at step cnt of a fill starting at word base (wraps within the block).
  function automatic logic [WORD_W-1:0] rotate_word(input logic [WORD_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
    return base + cnt[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_fill_fsm_onehot_decoder.sv
// Enabled N-to-2^N one-hot decoder; output is all-zero while disabled.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]        i_sel,
  input  logic                i_en,
  output logic [(1<<N)-1:0]   o_onehot
);

  // Decode the select into a single hot bit when enabled
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end else begin
      o_onehot = '0;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: fetches an 8-word block and steers it into the data array.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the fill at the missed word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int NUM_SETS        = cache_pkg::NUM_SETS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_detected,
  input  logic [15:0]                miss_address,
  input  logic                       victim_way,
  input  logic                       memory_data_valid,
  input  logic [15:0]                memory_data_in,
  output logic                       fsm_busy,
  output logic                       memory_read_en,
  output logic [15:0]                memory_address,
  output logic                       data_write,
  output logic                       data_way,
  output logic [NUM_SETS-1:0]        data_set_enable,
  output logic [WORDS_PER_BLOCK-1:0] data_word_enable,
  output logic [15:0]                data_in,
  output logic                       tag_write,
  output logic [5:0]                 tag_out,
  output logic                       critical_word_valid
);

  import cache_pkg::*;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_recv_cnt;
  miss_info_t        r_miss;
  logic              r_way;

  logic              w_fill;
  logic              w_issue_active;
  logic              w_accept;
  logic              w_last;
  logic [WORD_W-1:0] w_issue_word;
  logic [WORD_W-1:0] w_recv_word;

  assign w_fill         = (r_state == FILL_ACTIVE);
  assign w_issue_active = w_fill & (r_issue_cnt < CNT_FULL);
  assign w_accept       = memory_data_valid & w_fill & (r_recv_cnt < CNT_FULL);
  assign w_last         = w_accept & (r_recv_cnt == CNT_LAST);

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_issue_word = rotate_word(r_miss.word, r_issue_cnt);
  assign w_recv_word  = rotate_word(r_miss.word, r_recv_cnt);
`else
  assign w_issue_word = r_issue_cnt[WORD_W-1:0];
  assign w_recv_word  = r_recv_cnt[WORD_W-1:0];
`endif

  // Fill FSM, miss latch and issue/receive counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL_IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_miss      <= '0;
      r_way       <= 1'b0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          if (miss_detected) begin
            r_state     <= FILL_ACTIVE;
            r_miss.tag  <= miss_address[TAG_MSB:TAG_LSB];
            r_miss.set  <= miss_address[SET_MSB:SET_LSB];
            r_miss.word <= miss_address[WORD_MSB:WORD_LSB];
            r_way       <= victim_way;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end else begin
            r_state <= FILL_IDLE;
          end
        end
        FILL_ACTIVE: begin
          if (w_issue_active) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
          end
          if (w_accept) begin
            r_recv_cnt <= r_recv_cnt + CNT_W'(1);
          end
          if (w_last) begin
            r_state <= FILL_IDLE;
          end
        end
        default: begin
          r_state <= FILL_IDLE;
        end
      endcase
    end
  end

  onehot_decoder #(.N(SET_W)) u_set_dec (
    .i_sel    (r_miss.set),
    .i_en     (w_accept),
    .o_onehot (data_set_enable)
  );

  onehot_decoder #(.N(WORD_W)) u_word_dec (
    .i_sel    (w_recv_word),
    .i_en     (w_accept),
    .o_onehot (data_word_enable)
  );

  assign fsm_busy       = w_fill;
  assign memory_read_en = w_issue_active;
  // Reads are always word-aligned, so the byte lane of the miss address is masked off
  assign memory_address = w_issue_active
                        ? {r_miss.tag, r_miss.set, w_issue_word, miss_address[0] & 1'b0}
                        : 16'h0000;

  assign data_write          = w_accept;
  assign data_way            = w_accept & r_way;
  assign data_in             = memory_data_in;
  assign tag_write           = w_last;
  assign tag_out             = r_miss.tag;
  assign critical_word_valid = w_accept & (w_recv_word == r_miss.word);

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller that sits directly upstream of the 64-set, 2-way cache data array. On a miss it fetches the 8-word (16-byte) block from the pipelined multi-cycle main memory. It steers each returned word into the data array via one-hot set, word and way enables. On the last word it pulses a tag-array write. One instance serves the I-cache and one serves the D-cache.

Parameters:
WORDS_PER_BLOCK, 8, words fetched per fill; also the width of the word one-hot.
NUM_SETS, 64, sets in the data/tag array; also the width of the set one-hot.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
miss_detected  in  1  level; cache lookup missed this cycle
miss_address  in  16  byte address of the missing access
victim_way  in  1  way to refill (0 = first way, 1 = second way); sampled with the miss
memory_data_valid  in  1  one word returned from memory this cycle
memory_data_in  in  16  returned word
fsm_busy  out  1  fill in progress; pipeline stalls
memory_read_en  out  1  issue one word read this cycle
memory_address  out  16  word-aligned read address
data_write  out  1  write strobe to data array
data_way  out  1  way select to data array
data_set_enable  out  64  one-hot set enable
data_word_enable  out  8  one-hot word enable
data_in  out  16  word to write (equals memory_data_in)
tag_write  out  1  one-cycle pulse; write tag of the filled block
tag_out  out  6  tag to write (miss_address[15:10])
critical_word_valid  out  1  pulse when the originally missed word is written

Behaviour:
- Address split: tag [15:10], set [9:4], word [3:1], byte [0].
- States: IDLE and FILL.
- Reset (rst=0, asynchronous): state IDLE, both counters 0, latched registers 0. All outputs are 0 except data_in, which follows memory_data_in.
- IDLE, miss_detected=1: on the next edge go to FILL.
  - Latch miss_address[15:1] and victim_way.
  - Set issue_cnt=0 and recv_cnt=0.
  - fsm_busy goes high the cycle after the miss is seen.
- IDLE, miss_detected=0: stay in IDLE.
- FILL, issue side:
  - memory_read_en=1 while issue_cnt<8.
  - memory_address = {tag, set, issue_word[2:0], 1'b0}.
  - issue_cnt increments each cycle, so 8 consecutive issue cycles; then memory_read_en=0.
- FILL, receive side (data_write = memory_data_valid & FILL & recv_cnt<8):
  - data_word_enable = onehot(recv_word).
  - data_set_enable = onehot(latched set).
  - data_way = latched victim_way.
  - recv_cnt increments on each accepted valid.
- Completion: the cycle the 8th word is accepted, tag_write=1 with tag_out = latched tag. Next edge goes to IDLE and fsm_busy drops.
- Latency: with memory latency L, fill takes L+8 cycles from entering FILL.
- Ignored inputs:
  - memory_data_valid in IDLE, or after 8 words have been received.
  - miss_detected while in FILL; no queuing.
- Back-to-back misses: a miss asserted in the cycle after return to IDLE starts a new fill.
- Reset mid-fill: abort immediately with no tag_write. The partially written block stays tag-invalid.
- Counters are 4-bit. issue_word and recv_word are the low 3 bits.
- data_set_enable and data_word_enable are all-zero whenever data_write=0.
- critical_word_valid = data_write & (recv_word == latched miss word).

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - issue_word = (miss_word + issue_cnt) mod 8.
  - recv_word = (miss_word + recv_cnt) mod 8, wrapping 7→0.
  - critical_word_valid fires with the first returned word.
- Undefined:
  - issue_word = issue_cnt[2:0] and recv_word = recv_cnt[2:0], i.e. order 0..7.
  - critical_word_valid fires when word miss_word arrives.

Decomposition:
- Shared package cache_pkg holds:
  - field positions: TAG_MSB=15, TAG_LSB=10, SET_MSB=9, SET_LSB=4, WORD_MSB=3, WORD_LSB=1;
  - NUM_SETS and WORDS_PER_BLOCK;
  - state encodings FILL_IDLE=1'b0 and FILL_ACTIVE=1'b1.
- One sub-module, onehot_decoder: parameterised N-to-2^N decoder with an enable input. Instantiated twice: 6→64 for the set, 3→8 for the word.

Test Plan:
1. Miss at 0x1A36, way 1, memory latency 4:
   - memory_address 0x1A30, 0x1A32, … 0x1A3E on 8 consecutive cycles.
   - 8 data_write pulses with set one-hot bit 35, words 0..7, data_way=1.
   - tag_write with tag_out=0x06.
   - fsm_busy high for 12 cycles.
2. Same miss with CRITICAL_WORD_FIRST_EN defined:
   - addresses start 0x1A36, 0x1A38, … 0x1A3E, 0x1A30, … 0x1A34.
   - critical_word_valid on the first data_write.
3. memory_data_valid pulses in IDLE and a 9th pulse after completion: no data_write, no tag_write.
4. miss_detected held high throughout FILL: exactly one fill. A new fill starts the cycle after return to IDLE.
5. rst=0 after 3 words received: all outputs 0 immediately and no tag_write. After rst=1 and a miss at 0x0000, a clean fill to set 0.
6. Gapped returns (valid every other cycle): words written in order. tag_write only with the 8th word.
